// File: rtl/apb_master_bridge_if.sv
// Command/response and APB bus signals of apb_master_bridge, bundled as one interface.
// The master modport is the bridge itself; the slave modport is whatever sits around it.
`timescale 1ns/1ps
interface apb_master_bridge_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [DATA_WIDTH-1:0] cmd_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;
  logic [ADDR_WIDTH-1:0] paddr;
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pselx, penable, pwrite, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, prdata, pready, pslverr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           paddr, pselx, penable, pwrite, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// APB requester: turns valid/ready commands into SETUP/ACCESS transfers and returns
// one registered response per command, with a wait-state watchdog against hung slaves.
`timescale 1ns/1ps
module apb_master_bridge #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic               pclk,
  input  logic               presetn,
  apb_master_bridge_if.master bus
);

  localparam int WD_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state_q,     state_d;
  logic [WD_W-1:0]       wdog_q,      wdog_d;
  logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
  logic                  pselx_q,     pselx_d;
  logic                  penable_q,   penable_d;
  logic                  pwrite_q,    pwrite_d;
  logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_err_q,   rsp_err_d;

  logic accept;
  logic abort;

  assign bus.cmd_ready = (state_q == IDLE) && presetn;
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign abort         = (TIMEOUT != 0) && (wdog_q == WD_LAST);

  always_comb begin
    state_d     = state_q;
    wdog_d      = wdog_q;
    paddr_d     = paddr_q;
    pselx_d     = pselx_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        // The APB output flops double as the latched command for the whole transfer.
        if (accept) begin
          state_d   = SETUP;
          pselx_d   = 1'b1;
          penable_d = 1'b0;
          paddr_d   = bus.cmd_addr;
          pwrite_d  = bus.cmd_write;
          pwdata_d  = bus.cmd_write ? bus.cmd_wdata : '0;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        wdog_d    = '0;
      end
      ACCESS: begin
        // A ready slave on the abort edge still completes normally.
        if (bus.pready) begin
          state_d     = IDLE;
          pselx_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d   = bus.pslverr;
        end else if (abort) begin
          state_d     = IDLE;
          pselx_d     = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
        end else if (TIMEOUT != 0) begin
          wdog_d = wdog_q + WD_W'(1);
        end
      end
      default: begin
        state_d   = IDLE;
        pselx_d   = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= IDLE;
      wdog_q      <= '0;
      paddr_q     <= '0;
      pselx_q     <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wdog_q      <= wdog_d;
      paddr_q     <= paddr_d;
      pselx_q     <= pselx_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.paddr     = paddr_q;
  assign bus.pselx     = pselx_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: single transfers, wait states, slave error,
// watchdog abort, reset mid-transfer and back-to-back commands.
`timescale 1ns/1ps
module tb_apb_master_bridge;

  logic pclk = 1'b0;
  logic presetn;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 pclk = ~pclk;

  apb_master_bridge_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  apb_master_bridge #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (bus)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // One command end to end; waits = number of ACCESS cycles with pready low.
  task automatic xfer(input string tag, input logic wr, input logic [7:0] addr,
                      input logic [31:0] wd, input int waits, input logic [31:0] rd,
                      input logic err, input logic [31:0] exp_rdata, input logic exp_err);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wd;
    bus.pready    = 1'b0;
    check_val({tag, ".ready_idle"}, 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    check_val({tag, ".setup_psel"}, 32'(bus.pselx), 32'd1);
    check_val({tag, ".setup_pen"}, 32'(bus.penable), 32'd0);
    check_val({tag, ".pwrite"}, 32'(bus.pwrite), 32'(wr));
    check_val({tag, ".pwdata"}, bus.pwdata, wr ? wd : 32'd0);
    check_val({tag, ".ready_busy"}, 32'(bus.cmd_ready), 32'd0);
    step();
    for (int k = 0; k <= waits; k++) begin
      check_val({tag, ".acc_psel"}, 32'(bus.pselx), 32'd1);
      check_val({tag, ".acc_pen"}, 32'(bus.penable), 32'd1);
      check_val({tag, ".acc_paddr"}, 32'(bus.paddr), 32'(addr));
      check_val({tag, ".acc_rspv"}, 32'(bus.rsp_valid), 32'd0);
      bus.pready  = (k == waits);
      bus.prdata  = rd;
      bus.pslverr = err;
      step();
    end
    bus.pready  = 1'b0;
    bus.pslverr = 1'b0;
    check_val({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
    check_val({tag, ".rsp_rdata"}, bus.rsp_rdata, exp_rdata);
    check_val({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check_val({tag, ".done_psel"}, 32'(bus.pselx), 32'd0);
    check_val({tag, ".done_pen"}, 32'(bus.penable), 32'd0);
    check_val({tag, ".done_ready"}, 32'(bus.cmd_ready), 32'd1);
    step();
    check_val({tag, ".rsp_pulse"}, 32'(bus.rsp_valid), 32'd0);
    check_val({tag, ".rdata_hold"}, bus.rsp_rdata, exp_rdata);
  endtask

  initial begin
    int pulses;
    presetn       = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bus.prdata    = '0;
    bus.pready    = 1'b0;
    bus.pslverr   = 1'b0;

    #12;
    check_val("rst.psel", 32'(bus.pselx), 32'd0);
    check_val("rst.pen", 32'(bus.penable), 32'd0);
    check_val("rst.paddr", 32'(bus.paddr), 32'd0);
    check_val("rst.pwdata", bus.pwdata, 32'd0);
    check_val("rst.rspv", 32'(bus.rsp_valid), 32'd0);
    check_val("rst.ready", 32'(bus.cmd_ready), 32'd0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    step();

    xfer("wr10", 1'b1, 8'h10, 32'hDEADBEEF, 0, 32'h0, 1'b0, 32'h0, 1'b0);
    xfer("rd24", 1'b0, 8'h24, 32'hFFFF0000, 3, 32'h12345678, 1'b0, 32'h12345678, 1'b0);
    xfer("rderr", 1'b0, 8'h28, 32'h0, 1, 32'hA5A50001, 1'b1, 32'hA5A50001, 1'b1);
    xfer("rd_edge", 1'b0, 8'h2C, 32'h0, 15, 32'h00C0FFEE, 1'b0, 32'h00C0FFEE, 1'b0);

    // Hung slave: pready never rises.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h30;
    bus.prdata    = 32'hFFFFFFFF;
    bus.pready    = 1'b0;
    step();
    bus.cmd_valid = 1'b0;
    step();
    for (int k = 0; k < 15; k++) step();
    check_val("to.still_psel", 32'(bus.pselx), 32'd1);
    check_val("to.still_pen", 32'(bus.penable), 32'd1);
    check_val("to.no_rsp", 32'(bus.rsp_valid), 32'd0);
    step();
    check_val("to.rspv", 32'(bus.rsp_valid), 32'd1);
    check_val("to.err", 32'(bus.rsp_err), 32'd1);
    check_val("to.rdata", bus.rsp_rdata, 32'd0);
    check_val("to.psel", 32'(bus.pselx), 32'd0);
    check_val("to.pen", 32'(bus.penable), 32'd0);
    check_val("to.ready", 32'(bus.cmd_ready), 32'd1);
    step();

    // Reset pulled in the middle of ACCESS.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h50;
    bus.cmd_wdata = 32'hCAFEF00D;
    step();
    bus.cmd_valid = 1'b0;
    step();
    step();
    #2 presetn = 1'b0;
    #1;
    check_val("arst.psel", 32'(bus.pselx), 32'd0);
    check_val("arst.pen", 32'(bus.penable), 32'd0);
    check_val("arst.rspv", 32'(bus.rsp_valid), 32'd0);
    check_val("arst.err", 32'(bus.rsp_err), 32'd0);
    check_val("arst.paddr", 32'(bus.paddr), 32'd0);
    check_val("arst.ready", 32'(bus.cmd_ready), 32'd0);
    bus.pready = 1'b1;
    step();
    check_val("arst.hold_psel", 32'(bus.pselx), 32'd0);
    @(negedge pclk);
    presetn = 1'b1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (bus.rsp_valid === 1'b1) pulses++;
      check_val("arst.idle_psel", 32'(bus.pselx), 32'd0);
    end
    check_val("arst.no_rsp", 32'(pulses), 32'd0);
    check_val("arst.ready_back", 32'(bus.cmd_ready), 32'd1);
    bus.pready = 1'b0;
    xfer("wr_after_rst", 1'b1, 8'h54, 32'h600DCAFE, 1, 32'h0, 1'b0, 32'h0, 1'b0);

    // Back-to-back: second command waits on cmd_valid through the first.
    bus.cmd_valid = 1'b1;
    bus.cmd_write = 1'b1;
    bus.cmd_addr  = 8'h40;
    bus.cmd_wdata = 32'h11111111;
    bus.pready    = 1'b1;
    bus.prdata    = 32'h0BADF00D;
    pulses = 0;
    step();
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = 8'h44;
    check_val("b2b.a_psel", 32'(bus.pselx), 32'd1);
    check_val("b2b.a_paddr", 32'(bus.paddr), 32'h40);
    step();
    step();
    if (bus.rsp_valid === 1'b1) pulses++;
    check_val("b2b.a_rspv", 32'(bus.rsp_valid), 32'd1);
    check_val("b2b.a_rdata", bus.rsp_rdata, 32'd0);
    check_val("b2b.gap_psel", 32'(bus.pselx), 32'd0);
    check_val("b2b.ready_in_rsp", 32'(bus.cmd_ready), 32'd1);
    step();
    bus.cmd_valid = 1'b0;
    if (bus.rsp_valid === 1'b1) pulses++;
    check_val("b2b.b_psel", 32'(bus.pselx), 32'd1);
    check_val("b2b.b_paddr", 32'(bus.paddr), 32'h44);
    check_val("b2b.b_pwdata", bus.pwdata, 32'd0);
    step();
    if (bus.rsp_valid === 1'b1) pulses++;
    step();
    if (bus.rsp_valid === 1'b1) pulses++;
    check_val("b2b.b_rdata", bus.rsp_rdata, 32'h0BADF00D);
    check_val("b2b.pulses", 32'(pulses), 32'd2);
    bus.pready = 1'b0;
    step();
    check_val("b2b.end_rspv", 32'(bus.rsp_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
